// File: rtl/vga_text_pkg.sv
// vga_text_pkg: display/glyph defaults and move-direction indices shared by the text-window logic.
package vga_text_pkg;
   localparam int H_DISP_DEF  = 640;
   localparam int V_DISP_DEF  = 480;
   localparam int GLYPH_W_DEF = 8;
   localparam int GLYPH_H_DEF = 8;
   localparam int DIR_LEFT    = 3;
   localparam int DIR_RIGHT   = 2;
   localparam int DIR_UP      = 1;
   localparam int DIR_DOWN    = 0;
   function automatic logic [2:0] eff_scale(input logic [2:0] cs, input int max_s);
      return (cs == 3'd0) ? 3'd1 : (int'(cs) > max_s) ? 3'(max_s) : cs;
   endfunction
endpackage

// File: rtl/text_window_if.sv
// text_window_if: request inputs and window-position outputs of the text-window positioner.
interface text_window_if #(parameter int COORD_W = 10);
   logic [2:0]         charSize;
   logic [3:0]         offsetFlag;
   logic               frameEnd;
   logic [COORD_W-1:0] posHorStart;
   logic [COORD_W-1:0] posHorEnd;
   logic [COORD_W-1:0] posVerStart;
   logic [COORD_W-1:0] posVerEnd;
   logic               wrapH;
   logic               wrapV;
   logic               updated;
   modport master (
      output charSize, offsetFlag, frameEnd,
      input  posHorStart, posHorEnd, posVerStart, posVerEnd, wrapH, wrapV, updated
   );
   modport slave (
      input  charSize, offsetFlag, frameEnd,
      output posHorStart, posHorEnd, posVerStart, posVerEnd, wrapH, wrapV, updated
   );
endinterface

// File: rtl/offset_axis.sv
// offset_axis: next start/end/wrap of one window axis for a one-step move or a re-centre.
module offset_axis #(parameter int COORD_W = 10) (
   input  logic [COORD_W-1:0] start_i,
   input  logic [COORD_W-1:0] step_i,
   input  logic [COORD_W-1:0] disp_i,
   input  logic               dec_i,
   input  logic               inc_i,
   input  logic               recentre_i,
   output logic [COORD_W-1:0] start_o,
   output logic [COORD_W-1:0] end_o,
   output logic               wrap_o
);
   logic [COORD_W:0] s, st, d, dn, up, nx, e, ew;
   always_comb begin
      s = {1'b0, start_i};
      st = {1'b0, step_i};
      d = {1'b0, disp_i};
      dn = (s >= st) ? s - st : s + d - st;
      up = (s + st < d) ? s + st : s + st - d;
      nx = recentre_i ? (d - st) >> 1 : (dec_i ^ inc_i) ? (dec_i ? dn : up) : s;
      e = nx + st - 1'b1;
      ew = (e >= d) ? e - d : e;
      start_o = nx[COORD_W-1:0];
      end_o = ew[COORD_W-1:0];
      wrap_o = ew < nx;
   end
endmodule

// File: rtl/text_window_positioner.sv
// text_window_positioner: synchronises move requests and applies moves/re-centring at frame end.
module text_window_positioner
   import vga_text_pkg::*;
#(
   parameter int COORD_W   = 10,
   parameter int H_DISP    = H_DISP_DEF,
   parameter int V_DISP    = V_DISP_DEF,
   parameter int GLYPH_W   = GLYPH_W_DEF,
   parameter int GLYPH_H   = GLYPH_H_DEF,
   parameter int MAX_SCALE = 4
) (
   input  logic         clk,
   input  logic         reset,
   text_window_if.slave win
);
   localparam logic [COORD_W-1:0] HS0 = COORD_W'((H_DISP - GLYPH_W) / 2);
   localparam logic [COORD_W-1:0] VS0 = COORD_W'((V_DISP - GLYPH_H) / 2);
   logic [3:0] sync1_q, sync2_q, sync3_q, pend_q, pend_d, edge_det;
   logic [2:0] scale_q, eff;
   logic [COORD_W-1:0] hs_q, he_q, vs_q, ve_q, hs_d, he_d, vs_d, ve_d, step_h, step_v;
   logic wh_q, wv_q, upd_q, wh_d, wv_d, chg, apply;
   always_comb begin
      eff = eff_scale(win.charSize, MAX_SCALE);
      chg = eff != scale_q;
      edge_det = sync2_q & ~sync3_q;
      apply = win.frameEnd & (chg | (|pend_q));
      // edges seen during frameEnd survive into the next frame
      pend_d = win.frameEnd ? edge_det : pend_q | edge_det;
      // moves only apply when eff equals scale_q, so eff gives the right step in both cases
      step_h = COORD_W'(GLYPH_W * int'(eff));
      step_v = COORD_W'(GLYPH_H * int'(eff));
   end
   offset_axis #(.COORD_W(COORD_W)) u_hor (
      .start_i(hs_q), .step_i(step_h), .disp_i(COORD_W'(H_DISP)),
      .dec_i(pend_q[DIR_LEFT]), .inc_i(pend_q[DIR_RIGHT]), .recentre_i(chg),
      .start_o(hs_d), .end_o(he_d), .wrap_o(wh_d)
   );
   offset_axis #(.COORD_W(COORD_W)) u_ver (
      .start_i(vs_q), .step_i(step_v), .disp_i(COORD_W'(V_DISP)),
      .dec_i(pend_q[DIR_UP]), .inc_i(pend_q[DIR_DOWN]), .recentre_i(chg),
      .start_o(vs_d), .end_o(ve_d), .wrap_o(wv_d)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         pend_q <= '0;
         scale_q <= 3'd1;
         hs_q <= HS0;
         he_q <= HS0 + COORD_W'(GLYPH_W - 1);
         vs_q <= VS0;
         ve_q <= VS0 + COORD_W'(GLYPH_H - 1);
         wh_q <= 1'b0;
         wv_q <= 1'b0;
         upd_q <= 1'b0;
      end else begin
         sync1_q <= win.offsetFlag;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         pend_q <= pend_d;
         upd_q <= apply;
         if (apply) begin
            scale_q <= eff;
            hs_q <= hs_d;
            he_q <= he_d;
            vs_q <= vs_d;
            ve_q <= ve_d;
            wh_q <= wh_d;
            wv_q <= wv_d;
         end
      end
   end
   assign win.posHorStart = hs_q;
   assign win.posHorEnd = he_q;
   assign win.posVerStart = vs_q;
   assign win.posVerEnd = ve_q;
   assign win.wrapH = wh_q;
   assign win.wrapV = wv_q;
   assign win.updated = upd_q;
endmodule

// File: tb/tb_text_window_positioner.sv
// tb_text_window_positioner: directed vectors with hand-computed window positions.
module tb_text_window_positioner;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic u1, u2, upd_seen;
   int errors = 0;
   int checks = 0;
   text_window_if #(.COORD_W(10)) win();
   text_window_positioner dut (.clk(clk), .reset(reset), .win(win));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic press(input logic [3:0] m);
      @(negedge clk);
      win.offsetFlag = m;
      repeat (5) @(negedge clk);
      win.offsetFlag = 4'b0000;
      repeat (3) @(negedge clk);
   endtask
   task automatic frame();
      @(negedge clk);
      win.frameEnd = 1'b1;
      @(negedge clk);
      win.frameEnd = 1'b0;
      u1 = win.updated;
      @(negedge clk);
      u2 = win.updated;
   endtask
   task automatic chk_pos(input string tag, input int hs, input int he, input int vs, input int ve);
      chk({tag, " hs"}, int'(win.posHorStart), hs);
      chk({tag, " he"}, int'(win.posHorEnd), he);
      chk({tag, " vs"}, int'(win.posVerStart), vs);
      chk({tag, " ve"}, int'(win.posVerEnd), ve);
   endtask
   initial begin
      win.charSize = 3'd1;
      win.offsetFlag = 4'b0000;
      win.frameEnd = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      upd_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         upd_seen = upd_seen | win.updated;
      end
      chk_pos("reset", 316, 323, 236, 243);
      chk("reset wrapH", int'(win.wrapH), 0);
      chk("reset wrapV", int'(win.wrapV), 0);
      chk("idle updated", int'(upd_seen), 0);
      press(4'b1000);
      frame();
      chk_pos("left", 308, 315, 236, 243);
      chk("left upd1", int'(u1), 1);
      chk("left upd2", int'(u2), 0);
      repeat (38) begin
         press(4'b1000);
         frame();
      end
      chk_pos("walk", 4, 11, 236, 243);
      press(4'b1000);
      frame();
      chk_pos("wrap left", 636, 3, 236, 243);
      chk("wrap left wrapH", int'(win.wrapH), 1);
      press(4'b0100);
      frame();
      chk_pos("wrap right", 4, 11, 236, 243);
      chk("wrap right wrapH", int'(win.wrapH), 0);
      press(4'b1100);
      frame();
      chk_pos("both", 4, 11, 236, 243);
      chk("both upd", int'(u1), 1);
      press(4'b0010);
      frame();
      chk_pos("up", 4, 11, 228, 235);
      press(4'b0010);
      win.charSize = 3'd4;
      frame();
      chk_pos("scale4", 304, 335, 224, 255);
      chk("scale4 upd", int'(u1), 1);
      frame();
      chk_pos("scale4 discard", 304, 335, 224, 255);
      chk("idle frame upd", int'(u1), 0);
      win.charSize = 3'd7;
      frame();
      chk_pos("clamp7", 304, 335, 224, 255);
      chk("clamp7 upd", int'(u1), 0);
      win.charSize = 3'd0;
      frame();
      chk_pos("scale0", 316, 323, 236, 243);
      chk("scale0 upd", int'(u1), 1);
      @(negedge clk);
      win.offsetFlag = 4'b0001;
      @(negedge clk);
      @(negedge clk);
      win.frameEnd = 1'b1;
      @(negedge clk);
      win.frameEnd = 1'b0;
      chk_pos("coinc", 316, 323, 236, 243);
      chk("coinc upd", int'(win.updated), 0);
      win.offsetFlag = 4'b0000;
      repeat (3) @(negedge clk);
      frame();
      chk_pos("held down", 316, 323, 244, 251);
      chk("held down upd", int'(u1), 1);
      press(4'b0100);
      frame();
      chk_pos("pre reset", 324, 331, 244, 251);
      press(4'b1001);
      reset = 1'b0;
      #1;
      chk_pos("async reset", 316, 323, 236, 243);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      frame();
      chk_pos("post reset", 316, 323, 236, 243);
      chk("post reset upd", int'(u1), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
